// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.
// Latency: load accepted at edge N, done pulses in the cycle after edge N+WIDTH.
// Backpressure: load is ignored while busy; a load in the DONE cycle starts back-to-back.
// Optional feature: define MUL_SIGNED_EN to add the signed_mode port (two's-complement operands).

module seq_mult_param #(
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic                 load,
`ifdef MUL_SIGNED_EN
   input  logic                 signed_mode,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   mul_out
);

   localparam int OUT_W = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_mcand;    // multiplicand magnitude, fixed for the whole operation
   logic [WIDTH-1:0]   r_mplier;   // multiplier magnitude, shifted right one bit per step
   logic [OUT_W-1:0]   r_acc;      // running sum of partial products
   logic [CNT_W-1:0]   r_cnt;      // step index, also the shift applied to the multiplicand

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [OUT_W-1:0]   w_addend;
   logic [OUT_W-1:0]   w_acc_next;
   logic [OUT_W-1:0]   w_result;
   logic               w_last;

`ifdef MUL_SIGNED_EN
   // Sign handling is folded into operand capture and final write-back so the
   // step loop itself is always an unsigned magnitude multiply.
   logic               r_neg;
   logic               w_a_neg;
   logic               w_b_neg;

   assign w_a_neg = signed_mode & op_a[WIDTH-1];
   assign w_b_neg = signed_mode & op_b[WIDTH-1];
   // The most-negative value maps onto 2^(WIDTH-1), which still fits unsigned
   // in WIDTH bits, so no extra magnitude bit is needed.
   assign w_a_mag = w_a_neg ? (~op_a + WIDTH'(1)) : op_a;
   assign w_b_mag = w_b_neg ? (~op_b + WIDTH'(1)) : op_b;
`else
   assign w_a_mag = op_a;
   assign w_b_mag = op_b;
`endif

   // Partial product for the current step: multiplicand aligned by the step index.
   assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
   assign w_acc_next = r_acc + (r_mplier[0] ? w_addend : {OUT_W{1'b0}});
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_SIGNED_EN
   assign w_result = r_neg ? (~w_acc_next + OUT_W'(1)) : w_acc_next;
`else
   assign w_result = w_acc_next;
`endif

   // Control FSM and datapath: accept in IDLE/DONE, WIDTH steps in CALC, one-cycle DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mul_out  <= '0;
`ifdef MUL_SIGNED_EN
         r_neg    <= 1'b0;
`endif
      end else begin
         case (r_state)
            // DONE accepts a new load exactly like IDLE so products can stream
            // at one per WIDTH+1 cycles.
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (load) begin
                  r_mcand  <= w_a_mag;
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
`ifdef MUL_SIGNED_EN
                  r_neg    <= w_a_neg ^ w_b_neg;
`endif
                  busy     <= 1'b1;
                  r_state  <= S_CALC;
               end else begin
                  busy     <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end

            // One partial-product step per clock; load and operand inputs are
            // not looked at here, so changes during CALC cannot disturb the result.
            S_CALC: begin
               r_acc    <= w_acc_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  mul_out <= w_result;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_DONE;
               end
            end

            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and randomized checks of seq_mult_param at WIDTH=5 and WIDTH=8.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
// Every wait for done is bounded; an expired bound is reported as a failure.

module tb_seq_mult_param;

   logic        clk;
   logic        reset;

   logic [4:0]  a5, b5;
   logic        load5;
   logic        busy5, done5;
   logic [9:0]  out5;

   logic [7:0]  a8, b8;
   logic        load8;
   logic        busy8, done8;
   logic [15:0] out8;

`ifdef MUL_SIGNED_EN
   logic        smode5;
   logic        smode8;
`endif

   int tests_run;
   int tests_failed;

   seq_mult_param #(.WIDTH(5)) u_dut5 (
      .clk         (clk),
      .reset       (reset),
      .op_a        (a5),
      .op_b        (b5),
      .load        (load5),
`ifdef MUL_SIGNED_EN
      .signed_mode (smode5),
`endif
      .busy        (busy5),
      .done        (done5),
      .mul_out     (out5)
   );

   seq_mult_param #(.WIDTH(8)) u_dut8 (
      .clk         (clk),
      .reset       (reset),
      .op_a        (a8),
      .op_b        (b8),
      .load        (load8),
`ifdef MUL_SIGNED_EN
      .signed_mode (smode8),
`endif
      .busy        (busy8),
      .done        (done8),
      .mul_out     (out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one WIDTH=5 operation and count edges from accept to done (-1 on timeout).
   task automatic run5(input logic [4:0] a, input logic [4:0] b, output int lat,
                       output logic busy_acc, output logic done_acc);
      a5 = a; b5 = b; load5 = 1'b1;
      tick();
      busy_acc = busy5;
      done_acc = done5;
      load5 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (done5 === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
      a8 = a; b8 = b; load8 = 1'b1;
      tick();
      load8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done8 === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      tests_run++;
      if ({busy5, done5, out5} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset5: busy=%b done=%b out=%0d, want 0/0/0", busy5, done5, out5);
      end
      tests_run++;
      if ({busy8, done8, out8} !== 18'h0) begin
         tests_failed++;
         $display("FAIL reset8: busy=%b done=%b out=%0d, want 0/0/0", busy8, done8, out8);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_max_operands();
      int lat; logic ba, da;
      run5(5'd31, 5'd31, lat, ba, da);
      tests_run++;
      if (ba !== 1'b1 || da !== 1'b0) begin
         tests_failed++;
         $display("FAIL accept_flags: busy=%b done=%b, want 1/0", ba, da);
      end
      tests_run++;
      if (lat !== 5) begin
         tests_failed++;
         $display("FAIL latency_31x31: got %0d edges, want 5", lat);
      end
      tests_run++;
      if (out5 !== 10'd961 || busy5 !== 1'b0) begin
         tests_failed++;
         $display("FAIL prod_31x31: out=%0d busy=%b, want 961/0", out5, busy5);
      end
      tick();
      tests_run++;
      if (done5 !== 1'b0 || out5 !== 10'd961) begin
         tests_failed++;
         $display("FAIL done_width_31x31: done=%b out=%0d, want 0/961", done5, out5);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2; logic ba, da;
      run5(5'd0, 5'd17, lat1, ba, da);
      tests_run++;
      if (lat1 !== 5 || out5 !== 10'd0) begin
         tests_failed++;
         $display("FAIL zero_op: lat=%0d out=%0d, want 5/0", lat1, out5);
      end
      // still in the DONE cycle: issue the next load immediately
      run5(5'd13, 5'd6, lat2, ba, da);
      tests_run++;
      if (ba !== 1'b1 || da !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", ba, da);
      end
      tests_run++;
      if (lat2 + 1 !== 6 || out5 !== 10'd78) begin
         tests_failed++;
         $display("FAIL b2b_13x6: spacing=%0d out=%0d, want 6/78", lat2 + 1, out5);
      end
      tick();
      tests_run++;
      if (done5 !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_done_width: done=%b, want 0", done5);
      end
   endtask

   task automatic test_load_while_busy();
      int lat;
      a5 = 5'd9; b5 = 5'd7; load5 = 1'b1;
      tick();
      load5 = 1'b0;
      tick();                                   // step 1
      a5 = 5'd3; b5 = 5'd3; load5 = 1'b1;       // request during step 2
      tick();
      load5 = 1'b0;
      lat = -1;
      for (int k = 3; k <= 30; k++) begin
         tick();
         if (done5 === 1'b1) begin
            lat = k;
            break;
         end
      end
      tests_run++;
      if (lat !== 5 || out5 !== 10'd63) begin
         tests_failed++;
         $display("FAIL load_busy_9x7: lat=%0d out=%0d, want 5/63", lat, out5);
      end
      tick();
      tests_run++;
      if (busy5 !== 1'b0 || done5 !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_busy_after: busy=%b done=%b, want 0/0", busy5, done5);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat; int seen; logic ba, da;
      a5 = 5'd21; b5 = 5'd19; load5 = 1'b1;
      tick();
      load5 = 1'b0;
      tick(); tick(); tick();                   // three steps done
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if ({busy5, done5, out5} !== 12'h000) begin
         tests_failed++;
         $display("FAIL mid_reset: busy=%b done=%b out=%0d, want 0/0/0", busy5, done5, out5);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done5 === 1'b1 || busy5 === 1'b1) seen++;
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL mid_reset_quiet: %0d active cycles, want 0", seen);
      end
      run5(5'd2, 5'd3, lat, ba, da);
      tests_run++;
      if (lat !== 5 || out5 !== 10'd6) begin
         tests_failed++;
         $display("FAIL after_reset_2x3: lat=%0d out=%0d, want 5/6", lat, out5);
      end
   endtask

   task automatic test_width8();
      int lat;
      run8(8'd255, 8'd255, lat);
      tests_run++;
      if (lat !== 8 || out8 !== 16'd65025) begin
         tests_failed++;
         $display("FAIL w8_255x255: lat=%0d out=%0d, want 8/65025", lat, out8);
      end
      run8(8'd128, 8'd3, lat);
      tests_run++;
      if (out8 !== 16'd384) begin
         tests_failed++;
         $display("FAIL w8_128x3: out=%0d, want 384", out8);
      end
   endtask

   task automatic test_random();
      int lat; logic ba, da;
      logic [4:0] ra; logic [4:0] rb; logic [9:0] exp5;
      logic [7:0] sa; logic [7:0] sb; logic [15:0] exp8;
      for (int i = 0; i < 150; i++) begin
         ra = 5'($urandom_range(0, 31));
         rb = 5'($urandom_range(0, 31));
         exp5 = 10'(ra) * 10'(rb);
         run5(ra, rb, lat, ba, da);
         tests_run++;
         if (lat !== 5 || out5 !== exp5) begin
            tests_failed++;
            $display("FAIL rnd5 %0d*%0d: lat=%0d out=%0d, want 5/%0d", ra, rb, lat, out5, exp5);
         end
      end
      for (int i = 0; i < 150; i++) begin
         sa = 8'($urandom_range(0, 255));
         sb = 8'($urandom_range(0, 255));
         exp8 = 16'(sa) * 16'(sb);
         run8(sa, sb, lat);
         tests_run++;
         if (lat !== 8 || out8 !== exp8) begin
            tests_failed++;
            $display("FAIL rnd8 %0d*%0d: lat=%0d out=%0d, want 8/%0d", sa, sb, lat, out8, exp8);
         end
      end
   endtask

`ifdef MUL_SIGNED_EN
   task automatic test_signed();
      int lat; logic ba, da;
      smode5 = 1'b1;
      run5(5'b10000, 5'b10000, lat, ba, da);     // -16 * -16
      tests_run++;
      if (lat !== 5 || out5 !== 10'd256) begin
         tests_failed++;
         $display("FAIL s_m16xm16: lat=%0d out=%h, want 5/100", lat, out5);
      end
      run5(5'b10000, 5'd15, lat, ba, da);        // -16 * 15
      tests_run++;
      if (out5 !== 10'h310) begin
         tests_failed++;
         $display("FAIL s_m16x15: out=%h, want 310", out5);
      end
      smode5 = 1'b0;
      run5(5'd16, 5'd16, lat, ba, da);
      tests_run++;
      if (out5 !== 10'd256) begin
         tests_failed++;
         $display("FAIL u_16x16: out=%0d, want 256", out5);
      end
   endtask
`endif

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1;
      a5 = '0; b5 = '0; load5 = 1'b0;
      a8 = '0; b8 = '0; load8 = 1'b0;
`ifdef MUL_SIGNED_EN
      smode5 = 1'b0;
      smode8 = 1'b0;
`endif
      test_reset();
      test_max_operands();
      test_back_to_back();
      test_load_while_busy();
      test_reset_mid_op();
      test_width8();
`ifdef MUL_SIGNED_EN
      test_signed();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
